// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-channel LED mode mux with heartbeat watchdogs, activity
// stretch and an error flash override, all in usb_clk. Only I_alive_tog is
// asynchronous. Build option: define LED_ERROR_LATCH_EN to make the error
// override sticky until I_clear_error.
module led_status_ctrl #(
   parameter int unsigned pCHANNELS      = 4,
   parameter int unsigned pALIVE         = 2,
   parameter int unsigned pTICK_DIV      = 48000,
   parameter int unsigned pTIMEOUT       = 8,
   parameter int unsigned pSTRETCH       = 4,
   parameter logic [7:0]  pFLASH_PATTERN = 8'b0000_0101
) (
   input  logic                   usb_clk,
   input  logic                   reset_i,
   input  logic [pALIVE-1:0]      I_alive_tog,
   input  logic [pCHANNELS-1:0]   I_status,
   input  logic [2*pCHANNELS-1:0] I_mode,
   input  logic                   I_error,
   input  logic                   I_clear_error,
   output logic [pCHANNELS-1:0]   O_led,
   output logic [pALIVE-1:0]      O_alive,
   output logic                   O_error_active
);

   localparam int unsigned      PresW       = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;
   localparam logic [PresW-1:0] TickLast    = PresW'(pTICK_DIV - 1);
   localparam logic [7:0]       Timeout     = 8'(pTIMEOUT);
   localparam logic [7:0]       StretchLoad = 8'(pSTRETCH);

   logic [pALIVE-1:0]    sync1_q, sync2_q, sync3_q, edge_q;
   logic [pALIVE-1:0]    alive_q, alive_d, stretch_on;
   logic [PresW-1:0]     presc_q, presc_d;
   logic                 tick;
   logic [2:0]           step_q, step_d;
   logic                 err_q, err_d;
   logic [pCHANNELS-1:0] led_q, led_d;

`ifdef LED_ERROR_LATCH_EN
   // Sticky error; a new error beats a simultaneous clear
   assign err_d = I_error | (err_q & ~I_clear_error);
`else
   logic unused_clear_error;
   assign err_d              = I_error;
   assign unused_clear_error = I_clear_error;
`endif

   // Free-running tick prescaler and flash step sequencing
   always_comb begin
      tick    = (presc_q == TickLast);
      presc_d = tick ? '0 : presc_q + PresW'(1);
      if (err_d && !err_q) begin
         step_d = '0;                      // every new error starts at pattern bit 0
      end else if (err_d && tick) begin
         step_d = step_q + 3'd1;
      end else begin
         step_d = step_q;
      end
   end

   for (genvar s = 0; s < pALIVE; s++) begin : g_src
      logic [7:0] wdog_q, wdog_d, stretch_q, stretch_d;

      // Edge pulse clears the watchdog and reloads the stretch, beating any tick
      always_comb begin
         if (edge_q[s]) begin
            wdog_d    = '0;
            stretch_d = StretchLoad;
         end else begin
            wdog_d    = (tick && (wdog_q < Timeout)) ? wdog_q + 8'd1 : wdog_q;
            stretch_d = (tick && (stretch_q != '0)) ? stretch_q - 8'd1 : stretch_q;
         end
      end

      // Per-source watchdog and stretch counters; sources start dead
      always_ff @(posedge usb_clk) begin
         if (reset_i) begin
            wdog_q    <= Timeout;
            stretch_q <= '0;
         end else begin
            wdog_q    <= wdog_d;
            stretch_q <= stretch_d;
         end
      end

      // Next-state values feed the output flops so alive/stretch track the edge pulse
      assign alive_d[s]    = (wdog_d < Timeout);
      assign stretch_on[s] = (stretch_d != '0);
   end

   for (genvar c = 0; c < pCHANNELS; c++) begin : g_chan
      localparam int unsigned Src = c % pALIVE;
      logic led_c;

      // Error flash overrides the channel's selected mode
      always_comb begin
         if (err_d) begin
            led_c = pFLASH_PATTERN[step_d];
         end else begin
            unique case (I_mode[2*c +: 2])
               2'b00:   led_c = I_status[c];
               2'b01:   led_c = sync2_q[Src];
               2'b10:   led_c = stretch_on[Src];
               default: led_c = 1'b0;
            endcase
         end
      end

      assign led_d[c] = led_c;
   end

   // Synchroniser chain, prescaler, flash step and registered outputs
   always_ff @(posedge usb_clk) begin
      if (reset_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
         edge_q  <= '0;
         presc_q <= '0;
         step_q  <= '0;
         err_q   <= 1'b0;
         led_q   <= '0;
         alive_q <= '0;
      end else begin
         sync1_q <= I_alive_tog;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         edge_q  <= sync2_q ^ sync3_q;
         presc_q <= presc_d;
         step_q  <= step_d;
         err_q   <= err_d;
         led_q   <= led_d;
         alive_q <= alive_d;
      end
   end

   assign O_led          = led_q;
   assign O_alive        = alive_q;
   assign O_error_active = err_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: the stimulus side predicts each cycle's
// registered outputs from event timestamps and pushes them; a monitor pops and
// compares after every clock edge.
module tb_led_status_ctrl;

   localparam int NCH  = 4;
   localparam int NAL  = 2;
   localparam int TDIV = 4;
   localparam int TOUT = 3;
   localparam int STR  = 2;
   localparam int HMAX = 64;

   typedef struct packed {
      logic [NCH-1:0] led;
      logic [NAL-1:0] alive;
      logic           err;
   } exp_t;

   logic             usb_clk = 1'b0;
   logic             reset_i;
   logic [NAL-1:0]   I_alive_tog;
   logic [NCH-1:0]   I_status;
   logic [2*NCH-1:0] I_mode;
   logic             I_error;
   logic             I_clear_error;
   logic [NCH-1:0]   O_led;
   logic [NAL-1:0]   O_alive;
   logic             O_error_active;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: edge count since reset and event timestamps
   logic [7:0]     pat_v = 8'b0000_0101;
   int             e;
   logic [NAL-1:0] tog_hist [HMAX];
   int             last_edge [NAL];
   int             last_rise;
   logic           act_prev;
`ifdef LED_ERROR_LATCH_EN
   int             last_set;
   int             last_clr;
`endif

   led_status_ctrl #(
      .pCHANNELS     (NCH),
      .pALIVE        (NAL),
      .pTICK_DIV     (TDIV),
      .pTIMEOUT      (TOUT),
      .pSTRETCH      (STR),
      .pFLASH_PATTERN(8'b0000_0101)
   ) dut (
      .usb_clk       (usb_clk),
      .reset_i       (reset_i),
      .I_alive_tog   (I_alive_tog),
      .I_status      (I_status),
      .I_mode        (I_mode),
      .I_error       (I_error),
      .I_clear_error (I_clear_error),
      .O_led         (O_led),
      .O_alive       (O_alive),
      .O_error_active(O_error_active)
   );

   always #5 usb_clk = ~usb_clk;

   // Ticks fall on edges e with e % TDIV == 0; count those in (a, b]
   function automatic int ticks(int a, int b);
      return b / TDIV - a / TDIV;
   endfunction

   function automatic logic [NAL-1:0] tog_at(int idx);
      if (idx < 1) return '0;
      return tog_hist[idx % HMAX];
   endfunction

   function automatic void model_reset();
      e = 0;
      for (int s = 0; s < NAL; s++) last_edge[s] = -1;
      last_rise = -1;
      act_prev  = 1'b0;
`ifdef LED_ERROR_LATCH_EN
      last_set = -1;
      last_clr = -1;
`endif
   endfunction

   // Outputs after the next edge, given the inputs currently driven
   function automatic exp_t model_step();
      exp_t           x;
      logic [NAL-1:0] t3, t4, mirror;
      logic [NAL-1:0] st_on;
      logic           act;
      logic [1:0]     m;
      int             n, step, src;
      x = '0;
      e++;
      tog_hist[e % HMAX] = I_alive_tog;
      mirror = tog_at(e - 2);
      t3     = tog_at(e - 3);
      t4     = tog_at(e - 4);
      for (int s = 0; s < NAL; s++) begin
         if (t3[s] != t4[s]) last_edge[s] = e;
         if (last_edge[s] < 0) begin
            x.alive[s] = 1'b0;
            st_on[s]   = 1'b0;
         end else begin
            n          = ticks(last_edge[s], e);
            x.alive[s] = (n < TOUT);
            st_on[s]   = (n < STR);
         end
      end
`ifdef LED_ERROR_LATCH_EN
      if (I_error) last_set = e;
      else if (I_clear_error) last_clr = e;
      act = (last_set >= 0) && (last_set > last_clr);
`else
      act = I_error;
`endif
      if (act && !act_prev) last_rise = e;
      act_prev = act;
      step  = act ? ticks(last_rise, e) % 8 : 0;
      x.err = act;
      for (int c = 0; c < NCH; c++) begin
         src = c % NAL;
         m   = I_mode[2*c +: 2];
         if (act) x.led[c] = pat_v[step];
         else begin
            case (m)
               2'b00:   x.led[c] = I_status[c];
               2'b01:   x.led[c] = mirror[src];
               2'b10:   x.led[c] = st_on[src];
               default: x.led[c] = 1'b0;
            endcase
         end
      end
      return x;
   endfunction

   // Predict the outcome of the coming edge, then let it happen
   task automatic cyc();
      exp_t x;
      if (reset_i) begin
         model_reset();
         x = '0;
      end else begin
         x = model_step();
      end
      exp_q.push_back(x);
      @(posedge usb_clk);
      #1;
   endtask

   task automatic run(int n);
      repeat (n) cyc();
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, want %0h", name, $time, got, want);
      end
   endtask

   // Monitor: one expectation per clock edge, sampled 2 time units after it
   initial begin
      exp_t x;
      forever begin
         @(posedge usb_clk);
         #2;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("O_led", 32'(O_led), 32'(x.led));
            check("O_alive", 32'(O_alive), 32'(x.alive));
            check("O_error_active", 32'(O_error_active), 32'(x.err));
         end
      end
   end

   initial begin
      int rate;
      reset_i       = 1'b1;
      I_alive_tog   = '0;
      I_status      = '0;
      I_mode        = '0;
      I_error       = 1'b0;
      I_clear_error = 1'b0;
      run(3);
      reset_i = 1'b0;
      run(6);

      // Heartbeats: source 0 every 8 cycles, source 1 every 5, then silence
      I_mode   = 8'b11_10_01_00;
      I_status = 4'hF;
      for (int i = 0; i < 64; i++) begin
         if (i % 8 == 0) I_alive_tog[0] = ~I_alive_tog[0];
         if (i % 5 == 0) I_alive_tog[1] = ~I_alive_tog[1];
         cyc();
      end
      run(30);

      // Single toggles at varying spacing so reloads land on every tick phase
      for (int ph = 0; ph < 8; ph++) begin
         I_alive_tog[0] = ~I_alive_tog[0];
         cyc();
         run(ph + 1);
      end
      run(20);

      // Reset in the middle of a stretch
      I_alive_tog[0] = ~I_alive_tog[0];
      run(4);
      reset_i = 1'b1;
      cyc();
      reset_i = 1'b0;
      run(8);

      // Error flash for 40 cycles, then release
      I_error = 1'b1;
      run(40);
      I_error = 1'b0;
      run(10);
      I_error       = 1'b1;
      I_clear_error = 1'b1;
      run(3);
      I_error = 1'b0;
      run(5);
      I_clear_error = 1'b0;
      run(5);

      // Randomised traffic with varying heartbeat rates
      rate = 6;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rate = $urandom_range(2, 40);
         reset_i = ($urandom_range(0, 499) == 0);
         for (int s = 0; s < NAL; s++)
            if ($urandom_range(0, rate - 1) == 0) I_alive_tog[s] = ~I_alive_tog[s];
         I_status = NCH'($urandom);
         if ($urandom_range(0, 19) == 0) I_mode = (2*NCH)'($urandom);
         if ($urandom_range(0, 29) == 0) I_error = ~I_error;
         I_clear_error = ($urandom_range(0, 9) == 0);
         cyc();
      end
      reset_i = 1'b0;

      repeat (2) @(posedge usb_clk);
      #3;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised LED/status controller replacing the fixed two-LED mux and free-running clock-alive LEDs in the top level. It runs entirely in `usb_clk`. It synchronises toggle bits from foreign-clock heartbeat counters and runs a per-source watchdog to produce clean alive flags. It drives `pCHANNELS` LEDs, each with a runtime-selectable mode, and an error flash pattern overrides every mode.

## Interface
Parameters:
- `pCHANNELS`, 4, number of LED outputs.
- `pALIVE`, 2, number of heartbeat sources; channel i uses source i mod `pALIVE`.
- `pTICK_DIV`, 48000, `usb_clk` cycles per tick (≥2).
- `pTIMEOUT`, 8, ticks without a heartbeat edge before the source is declared dead (1..255).
- `pSTRETCH`, 4, ticks an activity LED stays lit after an edge (1..255).
- `pFLASH_PATTERN`, 8'b0000_0101, error pattern, bit k shown at flash step k.

Ports:
- `usb_clk`  in  1  sole clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `I_alive_tog`  in  `pALIVE`  heartbeat toggle bits from other clock domains (e.g. bit 22 of a free-running counter).
- `I_status`  in  `pCHANNELS`  per-channel status level (arm, capturing, …).
- `I_mode`  in  2*`pCHANNELS`  channel i mode in bits [2i+1:2i]: 00 status, 01 heartbeat mirror, 10 activity stretch, 11 off.
- `I_error`  in  1  error level.
- `I_clear_error`  in  1  one-cycle clear pulse; used only with `LED_ERROR_LATCH_EN`.
- `O_led`  out  `pCHANNELS`  registered LED drive.
- `O_alive`  out  `pALIVE`  registered per-source alive flag.
- `O_error_active`  out  1  registered, high while the flash override is in effect.

## Operation
- **Synchroniser.** Each `I_alive_tog` bit passes through two flops, then a third history flop. The edge pulse is registered as ff2 XOR ff3.
- **Tick.** The prescaler counts 0..`pTICK_DIV`-1 and wraps. The tick is a one-cycle pulse on the cycle the count equals `pTICK_DIV`-1. It is free-running, with no error resync.
- **Watchdog** (per source, 8 bits):
  - cleared to 0 on an edge pulse;
  - else +1 on tick, saturating at `pTIMEOUT`;
  - clear wins over increment when both occur in the same cycle;
  - `O_alive` = (count < `pTIMEOUT`).
- **Stretch counter** (per source, 8 bits):
  - loads `pSTRETCH` on an edge pulse;
  - else −1 on tick while nonzero;
  - load wins over decrement when both occur in the same cycle.
- **Flash step.** A 3-bit step counter forces to 0 on the cycle `error_active` rises, otherwise +1 on tick while `error_active`, wrapping 7→0.
- **error_active.** Equals `I_error` (see Configuration for the latched variant).
- **Channel i next value:**
  - if `error_active`: `pFLASH_PATTERN`[step];
  - else mode 00: `I_status`[i];
  - else mode 01: synchronised ff2 of its source;
  - else mode 10: stretch counter ≠ 0;
  - else mode 11: 0.

## Timing
- Reset values:
  - all outputs 0;
  - prescaler 0, step 0;
  - watchdogs = `pTIMEOUT` (dead until the first edge);
  - stretch counters 0;
  - synchroniser flops 0.
- Reset takes effect on the clock edge on which `reset_i` is high and overrides everything, including mid-flash and mid-stretch.
- Heartbeat edge:
  - first sampled at edge n;
  - ff2 at n+1, edge pulse at n+2;
  - mode-01 LED at n+2;
  - stretch LED, and `O_alive` rising, at n+3.
- `I_status` and mode changes reach `O_led` one cycle later.
- `I_error` rise:
  - `O_error_active` is high and `O_led` shows pattern bit 0 one cycle later;
  - `I_error` fall releases the LEDs one cycle later.
- No handshakes. Inputs other than `I_alive_tog` must already be synchronous to `usb_clk`.

## Configuration
- `LED_ERROR_LATCH_EN` defined:
  - `error_active` is a sticky flop, set by `I_error` and cleared by `I_clear_error`;
  - set wins when both occur in the same cycle;
  - the flop resets to 0.
- Undefined: `error_active` follows `I_error` level and `I_clear_error` is ignored.

## Test plan
Benches use `pTICK_DIV`=4, `pTIMEOUT`=3, `pSTRETCH`=2 and defaults otherwise.
- **Reset.** Release reset with all inputs 0 → `O_led`=0, `O_alive`=0, `O_error_active`=0. Assert reset during stretch → all cleared next edge.
- **Heartbeat and timeout.** Toggle `I_alive_tog[0]` every 8 cycles → `O_alive[0]`=1 from 3 cycles after the first toggle edge and stays 1. Stop toggling → `O_alive[0]` falls after the 3rd subsequent tick.
- **Activity stretch.** Channel 2 in mode 10 (source 0), single toggle → `O_led[2]` high 3 cycles after the edge and low after 2 ticks. A second toggle coinciding with a tick → counter reloads to 2, not 1.
- **Mode mux.** `I_mode`=8'b11_10_01_00, `I_status`=4'b1111, source 1 toggling → LED0=1, LED1 mirrors source 1 with 2-cycle lag, LED3=0.
- **Error flash.** Pulse `I_error` for 40 cycles → all LEDs show 1,0,1,0,0,0,0,0 per tick starting at step 0. LEDs return to mode outputs 1 cycle after the fall.
- **Latched error.** With `LED_ERROR_LATCH_EN`, pulse `I_error` for 1 cycle → flash continues until `I_clear_error`. Clear coinciding with `I_error`=1 → stays active.
